// File: rtl/path_replay_if.sv
// path_replay bus: replay command, move-list playback and path-point stream.
// The master side (list/controller) drives start, goal and moves; the slave
// side (path_replay) returns the read request, coordinates and status.
interface path_replay_if #(
  parameter int COORD_W = 4,
  parameter int STEP_W  = 9
);
  logic               start;
  logic [COORD_W-1:0] goal_x;
  logic [COORD_W-1:0] goal_y;
  logic [1:0]         dir_in;
  logic               dir_valid;
  logic               list_done;
  logic               rd_req;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pos_valid;
  logic [STEP_W-1:0]  step_count;
  logic               done;
  logic               err;

  modport master (
    output start, goal_x, goal_y, dir_in, dir_valid, list_done,
    input  rd_req, x, y, pos_valid, step_count, done, err
  );

  modport slave (
    input  start, goal_x, goal_y, dir_in, dir_valid, list_done,
    output rd_req, x, y, pos_valid, step_count, done, err
  );
endinterface

// File: rtl/path_replay.sv
// path_replay: undoes the LIFO move list from the goal back to the origin,
// emitting one (x, y) point per move plus step count and done/err levels.
// Optional feature macro PATH_BOUNDS_CHECK_EN: when defined, a move leaving
// 0..MAZE_DIM-1 is rejected and aborts the replay; otherwise coordinates wrap.
module path_replay #(
  parameter int COORD_W   = 4,
  parameter int MAZE_DIM  = 16,
  parameter int MAX_STEPS = 256,
  parameter int STEP_W    = 9
) (
  input  logic          CLK,
  input  logic          RST,
  path_replay_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE, ERR} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  if (MAZE_DIM > (1 << COORD_W)) begin : g_dim_chk
    $error("MAZE_DIM does not fit in COORD_W bits");
  end
  if ((1 << STEP_W) <= MAX_STEPS) begin : g_step_chk
    $error("STEP_W too narrow for MAX_STEPS");
  end

  // Inverse of a recorded move; arithmetic wraps at COORD_W bits.
  function automatic coord_t undo_move(input logic [1:0] dir, input coord_t c);
    coord_t r;
    r = c;
    case (dir)
      2'b00:   r.y = c.y + 1'b1;
      2'b01:   r.x = c.x - 1'b1;
      2'b10:   r.x = c.x + 1'b1;
      default: r.y = c.y - 1'b1;
    endcase
    return r;
  endfunction

`ifdef PATH_BOUNDS_CHECK_EN
  // True when undoing the move would leave the 0..MAZE_DIM-1 grid.
  function automatic logic leaves_grid(input logic [1:0] dir, input coord_t c);
    logic [COORD_W-1:0] max_c;
    logic               oob;
    max_c = COORD_W'(MAZE_DIM - 1);
    case (dir)
      2'b00:   oob = (c.y >= max_c);
      2'b01:   oob = (c.x == '0);
      2'b10:   oob = (c.x >= max_c);
      default: oob = (c.y == '0);
    endcase
    return oob;
  endfunction
`endif

  state_t             state, state_nxt;
  coord_t             pos_r, pos_nxt, moved;
  logic [STEP_W-1:0]  step_r, step_nxt;
  logic               rd_req_r, rd_req_nxt;
  logic               pv_r, pv_nxt;
  logic               done_r, done_nxt;
  logic               err_r, err_nxt;
  logic               bound_err;

  assign moved = undo_move(bus.dir_in, pos_r);

`ifdef PATH_BOUNDS_CHECK_EN
  assign bound_err = leaves_grid(bus.dir_in, pos_r);
`else
  assign bound_err = 1'b0;
`endif

  // Next-state and next-output decode; every target defaults to hold/idle.
  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos_r;
    step_nxt   = step_r;
    rd_req_nxt = 1'b0;
    pv_nxt     = 1'b0;
    done_nxt   = done_r;
    err_nxt    = err_r;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          pos_nxt    = '{x: bus.goal_x, y: bus.goal_y};
          step_nxt   = '0;
          done_nxt   = 1'b0;
          err_nxt    = 1'b0;
          rd_req_nxt = 1'b1;
          pv_nxt     = 1'b1;
          state_nxt  = PLAY;
        end
      end
      PLAY: begin
        if (bus.dir_valid && ((step_r == STEP_LIMIT) || bound_err)) begin
          // Rejected move: coordinate and count freeze, abort wins over list_done.
          err_nxt   = 1'b1;
          state_nxt = ERR;
        end else begin
          if (bus.dir_valid) begin
            pos_nxt  = moved;
            step_nxt = step_r + 1'b1;
            pv_nxt   = 1'b1;
          end
          if (bus.list_done) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs; all cleared asynchronously on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pos_r    <= '0;
      step_r   <= '0;
      rd_req_r <= 1'b0;
      pv_r     <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      pos_r    <= pos_nxt;
      step_r   <= step_nxt;
      rd_req_r <= rd_req_nxt;
      pv_r     <= pv_nxt;
      done_r   <= done_nxt;
      err_r    <= err_nxt;
    end
  end

  assign bus.rd_req     = rd_req_r;
  assign bus.x          = pos_r.x;
  assign bus.y          = pos_r.y;
  assign bus.pos_valid  = pv_r;
  assign bus.step_count = step_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_path_replay.sv
// Testbench for path_replay: table-driven replays plus hand-written corner
// sequences; a negedge monitor pops expected path points from a queue.
module tb_path_replay;
  localparam int CW = 4;
  localparam int SW = 9;
  localparam int MS = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  path_replay_if #(.COORD_W(CW), .STEP_W(SW)) bus ();

  path_replay #(
    .COORD_W(CW), .MAZE_DIM(16), .MAX_STEPS(MS), .STEP_W(SW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  typedef struct packed {
    logic [3:0] gx;
    logic [3:0] gy;
    logic [2:0] n;
    logic [7:0] dirs;   // move i at dirs[2*i +: 2]
    logic [3:0] ex;
    logic [3:0] ey;
    logic [8:0] esteps;
  } vec_t;

  int  checks = 0;
  int  passes = 0;
  pt_t exp_q[$];
  pt_t mon_p;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference inverse move with 4-bit wrap.
  function automatic pt_t model_undo(input logic [1:0] d, input pt_t p);
    pt_t r;
    r = p;
    case (d)
      2'b00:   r.y = p.y + 4'd1;
      2'b01:   r.x = p.x - 4'd1;
      2'b10:   r.x = p.x + 4'd1;
      default: r.y = p.y - 4'd1;
    endcase
    return r;
  endfunction

  // Path-point monitor: every pos_valid must match the next expected point.
  always @(negedge CLK) begin
    if (RST === 1'b0 && bus.pos_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pos_valid", 1, 0);
      end else begin
        mon_p = exp_q.pop_front();
        chk("point_x", int'(bus.x), int'(mon_p.x));
        chk("point_y", int'(bus.y), int'(mon_p.y));
      end
    end
  end

  task automatic start_replay(input logic [3:0] gx, input logic [3:0] gy);
    bus.goal_x = gx;
    bus.goal_y = gy;
    bus.start  = 1'b1;
    exp_q.push_back(pt_t'{gx, gy});
    tick();
    bus.start = 1'b0;
    chk("rd_req_pulse", int'(bus.rd_req), 1);
  endtask

  task automatic run_vec(input vec_t v);
    pt_t cur;
    start_replay(v.gx, v.gy);
    cur = pt_t'{v.gx, v.gy};
    for (int i = 0; i < int'(v.n); i++) begin
      bus.dir_in    = v.dirs[2*i +: 2];
      bus.dir_valid = 1'b1;
      cur = model_undo(bus.dir_in, cur);
      exp_q.push_back(cur);
      tick();
    end
    bus.dir_valid = 1'b0;
    bus.list_done = 1'b1;
    tick();
    bus.list_done = 1'b0;
    chk("rd_req_low", int'(bus.rd_req), 0);
    chk("vec_done", int'(bus.done), 1);
    chk("vec_err", int'(bus.err), 0);
    chk("vec_steps", int'(bus.step_count), int'(v.esteps));
    chk("vec_x", int'(bus.x), int'(v.ex));
    chk("vec_y", int'(bus.y), int'(v.ey));
    // Moves after completion must be ignored.
    bus.dir_in    = 2'b00;
    bus.dir_valid = 1'b1;
    tick();
    bus.dir_valid = 1'b0;
    tick();
    chk("done_hold_steps", int'(bus.step_count), int'(v.esteps));
    chk("done_hold_y", int'(bus.y), int'(v.ey));
    chk("done_hold", int'(bus.done), 1);
  endtask

  vec_t vecs[4];
  int   rd_cnt;

  initial begin
    vecs[0] = '{gx: 4'd2, gy: 4'd1, n: 3'd3, dirs: 8'b00_01_01_11, ex: 4'd0, ey: 4'd0, esteps: 9'd3};
    vecs[1] = '{gx: 4'd5, gy: 4'd5, n: 3'd4, dirs: 8'b10_00_10_00, ex: 4'd7, ey: 4'd7, esteps: 9'd4};
    vecs[2] = '{gx: 4'd9, gy: 4'd4, n: 3'd0, dirs: 8'b00_00_00_00, ex: 4'd9, ey: 4'd4, esteps: 9'd0};
    vecs[3] = '{gx: 4'd7, gy: 4'd3, n: 3'd2, dirs: 8'b00_00_01_11, ex: 4'd6, ey: 4'd2, esteps: 9'd2};

    RST           = 1'b1;
    bus.start     = 1'b0;
    bus.goal_x    = '0;
    bus.goal_y    = '0;
    bus.dir_in    = '0;
    bus.dir_valid = 1'b0;
    bus.list_done = 1'b0;
    tick();
    tick();
    chk("rst_rd_req", int'(bus.rd_req), 0);
    chk("rst_pos_valid", int'(bus.pos_valid), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_steps", int'(bus.step_count), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    RST = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Final move and list_done in the same cycle.
    start_replay(4'd0, 4'd1);
    bus.dir_in    = 2'b11;
    bus.dir_valid = 1'b1;
    bus.list_done = 1'b1;
    exp_q.push_back(pt_t'{4'd0, 4'd0});
    tick();
    bus.dir_valid = 1'b0;
    bus.list_done = 1'b0;
    chk("sim_pos_valid", int'(bus.pos_valid), 1);
    chk("sim_done", int'(bus.done), 1);
    chk("sim_y", int'(bus.y), 0);
    chk("sim_steps", int'(bus.step_count), 1);
    tick();

    // Step limit: fifth move is rejected.
    start_replay(4'd3, 4'd3);
    for (int i = 0; i < 5; i++) begin
      bus.dir_in    = 2'b00;
      bus.dir_valid = 1'b1;
      if (i < MS) exp_q.push_back(pt_t'{4'd3, 4'(4 + i)});
      tick();
    end
    bus.dir_valid = 1'b0;
    chk("lim_err", int'(bus.err), 1);
    chk("lim_done", int'(bus.done), 0);
    chk("lim_steps", int'(bus.step_count), MS);
    chk("lim_x", int'(bus.x), 3);
    chk("lim_y", int'(bus.y), 7);
    chk("lim_pos_valid", int'(bus.pos_valid), 0);
    bus.list_done = 1'b1;
    tick();
    bus.list_done = 1'b0;
    chk("lim_err_hold", int'(bus.err), 1);
    chk("lim_done_hold", int'(bus.done), 0);
    chk("lim_y_hold", int'(bus.y), 7);

    // Move below x=0 from goal (0,0).
    start_replay(4'd0, 4'd0);
    bus.dir_in    = 2'b01;
    bus.dir_valid = 1'b1;
`ifdef PATH_BOUNDS_CHECK_EN
    tick();
    bus.dir_valid = 1'b0;
    chk("bnd_err", int'(bus.err), 1);
    chk("bnd_x", int'(bus.x), 0);
    chk("bnd_pos_valid", int'(bus.pos_valid), 0);
    chk("bnd_steps", int'(bus.step_count), 0);
`else
    exp_q.push_back(pt_t'{4'd15, 4'd0});
    tick();
    bus.dir_valid = 1'b0;
    chk("wrap_x", int'(bus.x), 15);
    chk("wrap_pos_valid", int'(bus.pos_valid), 1);
    chk("wrap_err", int'(bus.err), 0);
    chk("wrap_steps", int'(bus.step_count), 1);
    bus.list_done = 1'b1;
    tick();
    bus.list_done = 1'b0;
    chk("wrap_done", int'(bus.done), 1);
`endif
    tick();

    // Reset mid-replay, then restart.
    start_replay(4'd4, 4'd4);
    for (int i = 0; i < 2; i++) begin
      bus.dir_in    = 2'b01;
      bus.dir_valid = 1'b1;
      exp_q.push_back(pt_t'{4'(3 - i), 4'd4});
      tick();
    end
    bus.dir_valid = 1'b0;
    tick();
    RST = 1'b1;
    #2;
    chk("mid_rst_rd_req", int'(bus.rd_req), 0);
    chk("mid_rst_pos_valid", int'(bus.pos_valid), 0);
    chk("mid_rst_x", int'(bus.x), 0);
    chk("mid_rst_y", int'(bus.y), 0);
    chk("mid_rst_steps", int'(bus.step_count), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    tick();
    RST = 1'b0;
    tick();
    start_replay(4'd3, 4'd3);
    chk("restart_steps", int'(bus.step_count), 0);
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rd_req === 1'b1) rd_cnt++;
    end
    chk("restart_rd_req_extra", rd_cnt, 0);
    bus.list_done = 1'b1;
    tick();
    bus.list_done = 1'b0;
    chk("restart_done", int'(bus.done), 1);
    chk("restart_x", int'(bus.x), 3);
    chk("restart_y", int'(bus.y), 3);
    tick();

    chk("points_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
